belt_box_packer: RTL and testbench

- Downstream stage of goods_quality_ctrl. Consumes the two sorted belt streams: belt A (quality >= 61) and belt B (quality <= 60).
- Buffers each belt in its own FIFO and packs BOX_SIZE consecutive items from one belt into a box.
- Emits one box summary per box (belt id, item count, quality sum/min/max) on a valid/ready handshake to the dispatch stage.
- A flush request drains partial boxes at end of shift.

---
 rtl/belt_pkg.sv | 30 +++
 rtl/belt_fifo.sv | 53 +++++
 rtl/belt_box_packer.sv | 136 +++++++++++++
 tb/tb_belt_box_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/belt_pkg.sv
// Shared types for the belt packing stage: belt ids, packer FSM states and
// the quality threshold that splits goods onto belt A / belt B upstream.
package belt_pkg;

    localparam int QW_DEFAULT     = 7;
    localparam int QUALITY_THRESH = 61;

    typedef logic [QW_DEFAULT-1:0] quality_t;

    typedef enum logic {
        BELT_A = 1'b0,
        BELT_B = 1'b1
    } belt_id_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } pack_state_e;

    // Round-robin pick: on a tie the belt that did not win last time goes.
    function automatic belt_id_e pick_belt(input logic cand_a, input logic cand_b,
                                           input belt_id_e rr_last);
        if (cand_a && cand_b) begin
            return (rr_last == BELT_A) ? BELT_B : BELT_A;
        end
        return cand_a ? BELT_A : BELT_B;
    endfunction

endpackage

// File: rtl/belt_fifo.sv
// First-word-fall-through item FIFO for one belt. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module belt_fifo #(
    parameter int DEPTH = 8,
    parameter int QW    = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [QW-1:0]                din,
    input  logic                         pop,
    output logic [QW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [QW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/belt_box_packer.sv
// Packs BOX_SIZE consecutive items from one belt into a box and reports the
// box summary (belt, count, sum/min/max) to the dispatch stage.
module belt_box_packer
    import belt_pkg::*;
#(
    parameter int BOX_SIZE = 4,
    parameter int DEPTH    = 8,
    parameter int QW       = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_belt_a,
    input  logic [QW-1:0]                     belt_a,
    input  logic                              valid_belt_b,
    input  logic [QW-1:0]                     belt_b,
    input  logic                              flush,
    output logic                              box_valid,
    input  logic                              box_ready,
    output logic                              box_belt,
    output logic [$clog2(BOX_SIZE+1)-1:0]     box_count,
    output logic [QW+$clog2(BOX_SIZE+1)-1:0]  box_sum,
    output logic [QW-1:0]                     box_min,
    output logic [QW-1:0]                     box_max,
    output logic                              ovf_a,
    output logic                              ovf_b,
    output logic                              busy,
    output pack_state_e                       dbg_state
);

    localparam int CW = $clog2(BOX_SIZE+1);
    localparam int SW = QW + CW;
    localparam int FW = $clog2(DEPTH+1);

    logic [FW-1:0] cnt_a, cnt_b, pick_cnt;
    logic [QW-1:0] dout_a, dout_b, item;
    logic          full_a, full_b, empty_a, empty_b;
    logic          wr_a, wr_b, pop_a, pop_b;
    logic          cand_a, cand_b, last_pop;
    logic [CW-1:0] fill_n;
    belt_id_e      pick;

    pack_state_e   state, state_nxt;
    belt_id_e      sel, rr_last;
    logic [CW-1:0] target, popped;
    logic [SW-1:0] acc_sum;
    logic [QW-1:0] acc_min, acc_max;
    logic          flush_pending, ovf_a_q, ovf_b_q;

    assign pop_a = (state == FILL) && (sel == BELT_A);
    assign pop_b = (state == FILL) && (sel == BELT_B);
    assign wr_a  = valid_belt_a & (~full_a | pop_a);
    assign wr_b  = valid_belt_b & (~full_b | pop_b);

    belt_fifo #(.DEPTH(DEPTH), .QW(QW)) u_fifo_a (
        .clk(clk), .rst(rst), .push(wr_a), .din(belt_a), .pop(pop_a),
        .dout(dout_a), .count(cnt_a), .full(full_a), .empty(empty_a)
    );

    belt_fifo #(.DEPTH(DEPTH), .QW(QW)) u_fifo_b (
        .clk(clk), .rst(rst), .push(wr_b), .din(belt_b), .pop(pop_b),
        .dout(dout_b), .count(cnt_b), .full(full_b), .empty(empty_b)
    );

    assign cand_a   = (cnt_a >= FW'(BOX_SIZE)) | (flush_pending & ~empty_a);
    assign cand_b   = (cnt_b >= FW'(BOX_SIZE)) | (flush_pending & ~empty_b);
    assign pick     = pick_belt(cand_a, cand_b, rr_last);
    assign pick_cnt = (pick == BELT_A) ? cnt_a : cnt_b;
    assign fill_n   = (pick_cnt >= FW'(BOX_SIZE)) ? CW'(BOX_SIZE) : CW'(pick_cnt);
    assign item     = (sel == BELT_A) ? dout_a : dout_b;
    assign last_pop = (popped == target - CW'(1));

    // Handshake: a box transfers on the edge where box_valid && box_ready;
    // while box_valid is high without box_ready every box_* output holds.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cand_a || cand_b) state_nxt = FILL;
            FILL:    if (last_pop)         state_nxt = EMIT;
            EMIT:    if (box_ready)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sel           <= BELT_A;
            rr_last       <= BELT_B;
            target        <= '0;
            popped        <= '0;
            acc_sum       <= '0;
            acc_min       <= '0;
            acc_max       <= '0;
            flush_pending <= 1'b0;
            ovf_a_q       <= 1'b0;
            ovf_b_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (valid_belt_a && !wr_a) ovf_a_q <= 1'b1;
            if (valid_belt_b && !wr_b) ovf_b_q <= 1'b1;
            flush_pending <= flush | (flush_pending & ~((state == IDLE) & empty_a & empty_b));
            case (state)
                IDLE: begin
                    if (cand_a || cand_b) begin
                        sel     <= pick;
                        rr_last <= pick;
                        target  <= fill_n;
                        popped  <= '0;
                        acc_sum <= '0;
                        acc_min <= '1;
                        acc_max <= '0;
                    end
                end
                FILL: begin
                    popped  <= popped + CW'(1);
                    acc_sum <= acc_sum + SW'(item);
                    if (item < acc_min) acc_min <= item;
                    if (item > acc_max) acc_max <= item;
                end
                default: ;
            endcase
        end
    end

    assign box_valid = (state == EMIT);
    assign box_belt  = sel;
    assign box_count = target;
    assign box_sum   = acc_sum;
    assign box_min   = acc_min;
    assign box_max   = acc_max;
    assign ovf_a     = ovf_a_q;
    assign ovf_b     = ovf_b_q;
    assign busy      = (state != IDLE) | flush_pending;
    assign dbg_state = state;

endmodule

// File: tb/tb_belt_box_packer.sv
// Directed bench for belt_box_packer: a table of single-belt boxes plus
// hand-written sequences for arbitration, flush, back-pressure and reset.
module tb_belt_box_packer;
    import belt_pkg::*;

    localparam int BOX_SIZE = 4;
    localparam int DEPTH    = 8;
    localparam int QW       = 7;
    localparam int CW       = 3;
    localparam int SW       = QW + CW;
    localparam int W        = 1 + CW + SW + 2*QW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_belt_a = 1'b0, valid_belt_b = 1'b0, flush = 1'b0;
    logic [QW-1:0] belt_a = '0, belt_b = '0;
    logic          box_ready = 1'b1;
    logic          box_valid, box_belt, ovf_a, ovf_b, busy;
    logic [CW-1:0] box_count;
    logic [SW-1:0] box_sum;
    logic [QW-1:0] box_min, box_max;
    pack_state_e   dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic belt;
        int   n;
        int   items[4];
        int   sum;
        int   mn;
        int   mx;
    } row_t;
    row_t rows[6];

    belt_box_packer #(.BOX_SIZE(BOX_SIZE), .DEPTH(DEPTH), .QW(QW)) dut (
        .clk(clk), .rst(rst),
        .valid_belt_a(valid_belt_a), .belt_a(belt_a),
        .valid_belt_b(valid_belt_b), .belt_b(belt_b),
        .flush(flush),
        .box_valid(box_valid), .box_ready(box_ready),
        .box_belt(box_belt), .box_count(box_count), .box_sum(box_sum),
        .box_min(box_min), .box_max(box_max),
        .ovf_a(ovf_a), .ovf_b(ovf_b), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pack_box(input logic belt, input int cnt, input int sum,
                                              input int mn, input int mx);
        return {belt, CW'(cnt), SW'(sum), QW'(mn), QW'(mx)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_belt_a = 1'b0;
        valid_belt_b = 1'b0;
        flush = 1'b0;
        box_ready = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic va, input int a, input logic vb, input int b, input logic fl);
        valid_belt_a = va;
        belt_a = QW'(a);
        valid_belt_b = vb;
        belt_b = QW'(b);
        flush = fl;
        tick();
        valid_belt_a = 1'b0;
        valid_belt_b = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check("boxes_outstanding", exp_q.size(), 0);
        tick();
        tick();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        if (!rst && box_valid && box_ready) begin
            got = {box_belt, box_count, box_sum, box_min, box_max};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL box_unexpected: got %0h expected no box", got);
            end else begin
                check("box_summary", got, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  lat;
        logic seen;

        rows[0] = '{1'b0, 4, '{61, 70, 100, 127}, 358, 61, 127};
        rows[1] = '{1'b1, 4, '{0, 10, 20, 60},     90,  0,  60};
        rows[2] = '{1'b0, 3, '{65, 66, 67, 0},     198, 65, 67};
        rows[3] = '{1'b1, 4, '{127, 127, 127, 127}, 508, 127, 127};
        rows[4] = '{1'b0, 1, '{0, 0, 0, 0},        0,   0,  0};
        rows[5] = '{1'b1, 2, '{60, 1, 0, 0},       61,  1,  60};

        for (int r = 0; r < 6; r++) begin
            do_reset();
            @(negedge clk);
            check("reset_outputs",
                  {box_valid, busy, ovf_a, ovf_b, box_belt, box_count, box_sum, box_min, box_max}, '0);
            check("reset_state", dbg_state, IDLE);
            tick();
            exp_q.push_back(pack_box(rows[r].belt, rows[r].n, rows[r].sum, rows[r].mn, rows[r].mx));
            for (int k = 0; k < rows[r].n; k++) begin
                if (rows[r].belt) push(1'b0, 0, 1'b1, rows[r].items[k], 1'b0);
                else              push(1'b1, rows[r].items[k], 1'b0, 0, 1'b0);
            end
            if (rows[r].n < BOX_SIZE) push(1'b0, 0, 1'b0, 0, 1'b1);
            drain(40);
            check("row_no_ovf", {ovf_a, ovf_b}, 2'b00);
        end

        // Latency from the 4th written item to box_valid
        do_reset();
        exp_q.push_back(pack_box(1'b0, 4, 358, 61, 127));
        push(1'b1, 61, 1'b0, 0, 1'b0);
        push(1'b1, 70, 1'b0, 0, 1'b0);
        push(1'b1, 100, 1'b0, 0, 1'b0);
        push(1'b1, 127, 1'b0, 0, 1'b0);
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (box_valid) begin
                seen = 1'b1;
                lat = i;
            end
        end
        check("latency_edges", lat, BOX_SIZE + 1);
        tick();
        drain(20);

        // Both belts fill together: A wins the first tie after reset
        do_reset();
        exp_q.push_back(pack_box(1'b0, 4, 326, 80, 83));
        exp_q.push_back(pack_box(1'b1, 4, 90, 0, 60));
        push(1'b1, 80, 1'b1, 0, 1'b0);
        push(1'b1, 81, 1'b1, 10, 1'b0);
        push(1'b1, 82, 1'b1, 20, 1'b0);
        push(1'b1, 83, 1'b1, 60, 1'b0);
        drain(60);
        check("tie_no_ovf", {ovf_a, ovf_b}, 2'b00);

        // Flush of a partial box, then busy falls once FIFOs are seen empty
        do_reset();
        exp_q.push_back(pack_box(1'b0, 3, 198, 65, 67));
        push(1'b1, 65, 1'b0, 0, 1'b0);
        push(1'b1, 66, 1'b0, 0, 1'b0);
        push(1'b1, 67, 1'b0, 0, 1'b0);
        push(1'b0, 0, 1'b0, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (box_valid) seen = 1'b1;
        end
        check("flush_box_seen", seen, 1'b1);
        check("busy_in_emit", busy, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_flush", busy, 1'b0);
        tick();
        drain(10);

        // Flush on the same edge as an item: the item is packed
        do_reset();
        exp_q.push_back(pack_box(1'b0, 1, 50, 50, 50));
        push(1'b1, 50, 1'b0, 0, 1'b1);
        drain(30);

        // Flush with partial boxes on both belts
        do_reset();
        exp_q.push_back(pack_box(1'b0, 3, 15, 3, 7));
        exp_q.push_back(pack_box(1'b1, 2, 90, 40, 50));
        push(1'b1, 3, 1'b1, 40, 1'b0);
        push(1'b1, 5, 1'b1, 50, 1'b0);
        push(1'b1, 7, 1'b0, 0, 1'b0);
        push(1'b0, 0, 1'b0, 0, 1'b1);
        drain(60);
        check("flush_both_busy", busy, 1'b0);

        // Reset in the middle of FILL discards the box and buffered items
        do_reset();
        push(1'b1, 90, 1'b0, 0, 1'b0);
        push(1'b1, 91, 1'b0, 0, 1'b0);
        push(1'b1, 92, 1'b0, 0, 1'b0);
        push(1'b1, 93, 1'b0, 0, 1'b0);
        tick();
        tick();
        tick();
        check("pre_reset_fill", dbg_state, FILL);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_fill_reset", {box_valid, busy, ovf_a, ovf_b}, 4'b0000);
        check("mid_fill_state", dbg_state, IDLE);
        tick();
        exp_q.push_back(pack_box(1'b0, 4, 10, 1, 4));
        push(1'b1, 1, 1'b0, 0, 1'b0);
        push(1'b1, 2, 1'b0, 0, 1'b0);
        push(1'b1, 3, 1'b0, 0, 1'b0);
        push(1'b1, 4, 1'b0, 0, 1'b0);
        drain(30);

        // Back-pressure: box held, FIFO fills to DEPTH, next item dropped
        do_reset();
        box_ready = 1'b0;
        for (int k = 0; k < 12; k++) push(1'b0, 0, 1'b1, 5, 1'b0);
        @(negedge clk);
        check("hold_valid", box_valid, 1'b1);
        check("hold_summary_1", {box_belt, box_count, box_sum, box_min, box_max},
              pack_box(1'b1, 4, 20, 5, 5));
        check("ovf_b_before_drop", ovf_b, 1'b0);
        tick();
        push(1'b0, 0, 1'b1, 5, 1'b0);
        @(negedge clk);
        check("ovf_b_after_drop", ovf_b, 1'b1);
        check("hold_summary_2", {box_belt, box_count, box_sum, box_min, box_max},
              pack_box(1'b1, 4, 20, 5, 5));
        tick();
        exp_q.push_back(pack_box(1'b1, 4, 20, 5, 5));
        exp_q.push_back(pack_box(1'b1, 4, 20, 5, 5));
        exp_q.push_back(pack_box(1'b1, 4, 20, 5, 5));
        exp_q.push_back(pack_box(1'b1, 1, 5, 5, 5));
        box_ready = 1'b1;
        for (int i = 0; i < 20 && dbg_state != FILL; i++) tick();
        check("refill_started", dbg_state, FILL);
        // FIFO is full here; this push lands on the first pop edge
        push(1'b0, 0, 1'b1, 5, 1'b1);
        drain(80);
        check("ovf_sticky", {ovf_a, ovf_b}, 2'b01);

        // Both belts every cycle: boxes alternate A,B,A,B
        do_reset();
        exp_q.push_back(pack_box(1'b0, 4, 400, 100, 100));
        exp_q.push_back(pack_box(1'b1, 4, 4, 1, 1));
        exp_q.push_back(pack_box(1'b0, 4, 400, 100, 100));
        exp_q.push_back(pack_box(1'b1, 4, 4, 1, 1));
        for (int k = 0; k < 8; k++) push(1'b1, 100, 1'b1, 1, 1'b0);
        drain(100);
        check("alt_no_ovf", {ovf_a, ovf_b}, 2'b00);
        check("alt_idle", dbg_state, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
